// File: rtl/rv_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv_pipe_stage
// Brief    : Valid/ready register pipeline with backpressure, bubble collapse
//            and synchronous flush. Only control state is reset.
// Revision : 1.0 - initial release
// ============================================================================
module rv_pipe_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] d_q  [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_xfer;
    logic             out_xfer;

    // Ready ripples from the output back to the input; an empty stage is
    // always ready, which is what lets bubbles collapse.
    always_comb begin
        rdy[DEPTH] = out_ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    assign up_v = (v_q << 1) | DEPTH'(in_valid_i && !flush_i);

    for (genvar k = 0; k < DEPTH; k++) begin : g_up_data
        if (k == 0) begin : g_head
            assign up_d[k] = in_data_i;
        end else begin : g_body
            assign up_d[k] = d_q[k-1];
        end
    end

    always_comb begin
        v_d = (rdy[DEPTH-1:0] & up_v) | (~rdy[DEPTH-1:0] & v_q);
        if (flush_i) begin
            v_d = '0;
        end
    end

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q     <= '0;
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    // Datapath flops carry no reset; their contents only matter where v_q is set.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
                d_q[k] <= up_d[k];
            end
        end
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = v_q[DEPTH-1] && !flush_i;
    assign out_data_o  = d_q[DEPTH-1];
    assign count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_pipe_stage
// Brief    : Checks a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=16 instance against
//            a timestamped FIFO reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_pipe_stage;
    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = '0;

    logic        ir4, ov4, ir1, ov1;
    logic [7:0]  od4;
    logic [15:0] od1;
    logic [2:0]  cnt4;
    logic [0:0]  cnt1;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference: each instance is a FIFO whose entries carry the first cycle
    // they may appear at the output (accept cycle + DEPTH).
    logic [15:0] md [2][8];
    int          mt [2][8];
    int          mhead [2];
    int          msize [2];
    int          dep [2] = '{4, 1};

    always #5 clk = ~clk;

    rv_pipe_stage #(.WIDTH(8), .DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir4), .in_data_i(in_data[7:0]),
        .out_valid_o(ov4), .out_ready_i(out_ready), .out_data_o(od4),
        .count_o(cnt4)
    );

    rv_pipe_stage #(.WIDTH(16), .DEPTH(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(ir1), .in_data_i(in_data),
        .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1),
        .count_o(cnt1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            mhead[m] = 0;
            msize[m] = 0;
        end
    endtask

    // Drive one cycle, check both instances mid-cycle, then advance the model.
    task automatic cycle(input bit iv, input bit ordy, input bit fl, input logic [15:0] data,
                         output bit acc4, output bit acc1);
        bit          ex_ir [2];
        bit          ex_ov [2];
        bit          ix [2];
        bit          ox [2];
        logic        got_ir, got_ov;
        logic [15:0] got_d, mask;
        int          got_c;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = data;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            ex_ir[m] = !fl && (msize[m] < dep[m] || ordy);
            ex_ov[m] = !fl && msize[m] > 0 && mt[m][mhead[m]] <= cyc;
            if (m == 0) begin
                got_ir = ir4; got_ov = ov4; got_d = {8'h00, od4}; got_c = int'(cnt4);
                mask = 16'h00FF;
            end else begin
                got_ir = ir1; got_ov = ov1; got_d = od1; got_c = int'(cnt1);
                mask = 16'hFFFF;
            end
            check_eq($sformatf("in_ready_d%0d", dep[m]), 32'(got_ir), 32'(ex_ir[m]));
            check_eq($sformatf("out_valid_d%0d", dep[m]), 32'(got_ov), 32'(ex_ov[m]));
            check_eq($sformatf("count_d%0d", dep[m]), got_c, msize[m]);
            if (ex_ov[m]) begin
                check_eq($sformatf("out_data_d%0d", dep[m]), 32'(got_d), 32'(md[m][mhead[m]] & mask));
            end
            ix[m] = iv && ex_ir[m];
            ox[m] = ex_ov[m] && ordy;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (fl) begin
                msize[m] = 0;
            end else begin
                if (ox[m]) begin
                    mhead[m] = (mhead[m] + 1) % 8;
                    msize[m]--;
                end
                if (ix[m]) begin
                    md[m][(mhead[m] + msize[m]) % 8] = data;
                    mt[m][(mhead[m] + msize[m]) % 8] = cyc + dep[m];
                    msize[m]++;
                end
            end
        end
        cyc++;
        #1;
        acc4 = ix[0];
        acc1 = ix[1];
    endtask

    initial begin
        bit          a4, a1;
        logic [15:0] idx;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid_d4", 32'(ov4), 0);
        check_eq("rst_count_d4", 32'(cnt4), 0);
        check_eq("rst_in_ready_d4", 32'(ir4), 1);
        check_eq("rst_out_valid_d1", 32'(ov1), 0);
        check_eq("rst_in_ready_d1", 32'(ir1), 1);
        rst = 1'b0;

        // Back-to-back streaming with the sink always ready.
        for (int i = 0; i < 12; i++) begin
            cycle(i < 8, 1'b1, 1'b0, 16'(i + 1), a4, a1);
        end
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0, a4, a1);

        // Backpressure: offer 0x10..0x14 into a stalled sink, then release.
        idx = 16'h10;
        for (int i = 0; i < 14; i++) begin
            cycle(idx <= 16'h14, i >= 6, 1'b0, idx, a4, a1);
            if (a4) idx++;
        end
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0, a4, a1);

        // Bubble collapse: two words separated by idle cycles, sink stalled.
        cycle(1'b1, 1'b0, 1'b0, 16'hA1, a4, a1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, a4, a1);
        cycle(1'b1, 1'b0, 1'b0, 16'hA2, a4, a1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, a4, a1);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0, a4, a1);

        // Flush with three words held and a word offered in the flush cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'hB1 + 16'(i), a4, a1);
        cycle(1'b1, 1'b0, 1'b1, 16'hB4, a4, a1);
        cycle(1'b1, 1'b1, 1'b0, 16'hB5, a4, a1);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0, a4, a1);

        // Asynchronous reset between edges with three words in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'hC1 + 16'(i), a4, a1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out_valid_d4", 32'(ov4), 0);
        check_eq("async_rst_count_d4", 32'(cnt4), 0);
        check_eq("async_rst_out_valid_d1", 32'(ov1), 0);
        check_eq("async_rst_count_d1", 32'(cnt1), 0);
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 16'h0, a4, a1);

        // Single-stage instance: continuous input, sink alternating ready.
        idx = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (i % 2) == 0, 1'b0, idx, a4, a1);
            if (a1) idx++;
        end
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 16'h0, a4, a1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, 16'($urandom), a4, a1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rv_pipe_stage.md
# rv_pipe_stage

Parametrised valid/ready register pipeline, the successor to our single resettable-flop-plus-follower pattern. Moves WIDTH-bit words through DEPTH register stages with full backpressure and bubble collapsing. Only control flops (per-stage valid bits, occupancy count) are reset. Data flops are non-reset, enable-only followers, keeping reset fan-out off the datapath. It sits between any two streaming blocks that need retiming or a small elastic buffer.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- clk_i  input  1  single clock, all flops on rising edge
- rst_i  input  1  reset, asynchronous, active-high; clears control state immediately
- flush_i  input  1  synchronous flush, active-high
- in_valid_i  input  1  upstream word valid
- in_ready_o  output  1  block accepts word this cycle
- in_data_i  input  WIDTH  upstream word
- out_valid_o  output  1  out_data_o holds a valid word
- out_ready_i  input  1  downstream accepts word this cycle
- out_data_o  output  WIDTH  word at stage DEPTH-1
- count_o  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- Stage k (0..DEPTH-1) has a valid bit v[k] and data register d[k]. Stage 0 is input side; stage DEPTH-1 drives out_data_o and out_valid_o.
- Control flops v[*] and count_o are in always blocks with async rst_i. Data flops d[*] are in separate blocks with no reset and load only when enabled.
- Ready chain is combinational:
  - r[DEPTH] = out_ready_i
  - r[k] = !v[k] || r[k+1]
  - in_ready_o = r[0] && !flush_i
- Stage k loads when r[k] is high. On load, d[k] ← upstream data (in_data_i for k=0, else d[k-1]) and v[k] ← upstream valid (in_valid_i && !flush_i for k=0, else v[k-1]).
- When r[k] is low, stage k holds d[k] and v[k].
- Bubbles collapse: an empty stage loads even when the downstream stage is stalled.
- Transfers:
  - input transfer = in_valid_i && in_ready_o
  - output transfer = out_valid_o && out_ready_i
- count_o: +1 on input transfer only, −1 on output transfer only, unchanged when both or neither occur.
- out_valid_o = v[DEPTH-1] && !flush_i. Output transfers cannot occur in a flush cycle.
- Flush: at the edge ending a cycle with flush_i high, all v[*] ← 0 and count_o ← 0. The input word in that cycle is not accepted. d[*] is don't-care.
- Order is strictly preserved. No word is duplicated or dropped except by flush or reset.

## Timing
- Reset values: v[*]=0, count_o=0, out_valid_o=0, in_ready_o=1 (when flush_i low). out_data_o and d[*] are undefined after reset.
- Reset asserted mid-operation: out_valid_o and count_o go to 0 asynchronously, without waiting for a clock edge. In-flight words are lost.
- Reset deassertion is synchronised externally; the block adds no synchroniser.
- Latency with the pipeline empty and out_ready_i high: a word accepted in cycle c appears on out in cycle c+DEPTH.
- Throughput: one word per cycle with out_ready_i held high.
- Full case: count_o=DEPTH and out_ready_i=0 → in_ready_o=0. With out_ready_i=1, in_ready_o=1 in the same cycle, giving simultaneous pop and push with count unchanged.
- out_data_o is checked only when out_valid_o=1. It stays stable while out_valid_o=1 and out_ready_i=0.
- Combinational paths:
  - out_ready_i → in_ready_o through the ready chain
  - flush_i → in_ready_o
  - flush_i → out_valid_o

## Test plan
- Reset: assert rst_i between clock edges with 3 words in flight → out_valid_o=0 and count_o=0 immediately. After release, in_ready_o=1.
- Streaming, DEPTH=4, WIDTH=8: present 0x01..0x08 back-to-back from cycle 0 with out_ready_i=1 → 0x01 on out in cycle 4, then one word per cycle in order. count_o steady at 4.
- Backpressure: out_ready_i=0, offer 0x10..0x14 → 0x10..0x13 accepted, in_ready_o low from the 5th cycle, count_o=4. Raise out_ready_i → 0x10 pops and 0x14 is accepted the same cycle. Output order is 0x10..0x14.
- Bubble collapse: push 0xA1, idle 2 cycles, push 0xA2, with out_ready_i=0 → count_o=2 and in_ready_o=1. On release, 0xA1 then 0xA2 on consecutive cycles.
- Flush: count_o=3 and in_valid_i=1 with flush_i high one cycle → that input is not accepted. Next cycle count_o=0, out_valid_o=0, in_ready_o=1. The next word pushed exits after DEPTH cycles.
- DEPTH=1, WIDTH=16: alternate out_ready_i 1/0 with continuous input 0x0001, 0x0002, … → no loss or duplication. Latency is 1 cycle when unstalled.
